sc_uni_decode: RTL and testbench
================================

# sc_uni_decode

Stochastic-to-binary decoder for unipolar bitstreams in the MAC16 stochastic datapath. Counts the 1s in a stream over a fixed window of `WINDOW` valid bits, by default one full 8-bit LFSR period of 255 bits, and returns the count as a binary value. The result is delivered over a valid/ready handshake. It sits at the output of the stochastic multiplier/MAC lanes and closes the loop from stream back to binary. `iStart` is driven in the same cycle as the encoders' seed/operand load.

## Interface
- `DATAWD`, 8: width of the count, the window counter and the result. Requires `WINDOW <= 2**DATAWD - 1`.
- `WINDOW`, 255: number of valid stream bits accumulated per conversion. Must be at least 1.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous reset, active low.
- `iStart`  in  1: start (or restart) a conversion.
- `iBit`  in  1: unipolar stream bit.
- `iBitVld`  in  1: `iBit` is valid this cycle. Cycles with this low are neither counted nor advance the window.
- `iReady`  in  1: downstream accepts the result.
- `oC`  out  `DATAWD`: result, the count of 1s in the last completed window.
- `oValid`  out  1: `oC` holds a new, unconsumed result.
- `oBusy`  out  1: accumulation in progress.

## Operation
- FSM states are IDLE, ACCUM and DONE. Internal registers:
  - `acc` (`DATAWD`): running count of 1s.
  - `win` (`DATAWD`): number of valid bits taken so far.
- IDLE:
  - `iStart` = 1 clears `acc` and `win` and moves to ACCUM.
  - `iBit` is ignored.
- ACCUM, on each edge with `iBitVld` = 1:
  - `win` increments.
  - `acc` increments when `iBit` = 1.
- ACCUM completion:
  - The edge that takes the `WINDOW`-th valid bit writes `oC` with the final count, including that bit.
  - The same edge sets `oValid` and moves to DONE.
- ACCUM restart: `iStart` = 1 in ACCUM clears `acc` and `win` and stays in ACCUM. The bit presented in that cycle is discarded. `oC` and `oValid` are unchanged.
- DONE:
  - Holds `oC` and `oValid` = 1. Stream bits are dropped.
  - On `oValid` & `iReady`, `oValid` clears.
  - Next state after the transfer is IDLE, or ACCUM if `iStart` = 1 in the same cycle. The transfer and the new start both take effect; `acc` and `win` are cleared.
  - `iStart` without `iReady` in DONE is ignored, so a result is never overwritten unconsumed.
- `oBusy` = 1 exactly while in ACCUM.
- `oC` is registered and is not cleared by `iStart`. It changes only on a window completion.
- Arithmetic: `acc` never exceeds `WINDOW`, so no overflow and no saturation logic is needed. Result scaling is count/`WINDOW`; no division is done in this block.
- Reset, asynchronous and effective mid-operation: state goes to IDLE and `oC`, `oValid`, `oBusy`, `acc` and `win` all go to 0. A partial count is lost.

## Timing
- `iStart` sampled high at edge k puts the block in ACCUM from edge k. The first bit counted is the one sampled at edge k+1.
- With `iBitVld` held high, bits are taken at edges k+1 through k+`WINDOW`. `oValid` rises after edge k+`WINDOW`, so the result appears `WINDOW` cycles after the start edge. That is 255 for the defaults.
- Each `iBitVld` = 0 cycle in ACCUM delays completion by one cycle.
- Handshake:
  - The transfer occurs on an edge where `oValid` & `iReady` are both high.
  - `oValid` falls after that edge.
  - `oC` stays stable while `oValid` = 1.
  - `iReady` may be high before `oValid`, and it has no combinational path to any output.
- Back-to-back: a start issued in the transfer cycle gives a new result `WINDOW` cycles later, with no dead cycle.

## Test plan
- All-ones stream, `iBitVld` = 1, default parameters, start at edge k, `iReady` = 1 -> `oValid` rises after edge k+255 with `oC` = 255. `oBusy` is high for 255 cycles.
- All-zeros stream, then alternating 1,0,... starting with 1 -> `oC` = 0, then `oC` = 128.
- All-ones stream with `iBitVld` low for 10 scattered cycles -> completion after edge k+265 with `oC` = 255. Invalid-cycle bits are not counted.
- All-ones stream with `iReady` held low 5 cycles after `oValid` rises -> `oC` = 255 and `oValid` hold; extra bits and an `iStart` pulse in DONE are ignored. Transfer happens on the 6th cycle, then IDLE.
- Restart: all-ones stream, `iStart` again 100 bits into ACCUM -> `oC` = 255 after edge (restart edge + 255), and no result from the aborted window. Also assert `iStart` together with a DONE transfer -> the next conversion starts that edge.
- Assert `rst_n` low at bit 50 of ACCUM -> `oC`, `oValid`, `oBusy` = 0 immediately. After release the block is IDLE and a fresh start yields the full 255-bit count.

Source files
------------

// File: rtl/sc_uni_decode.sv
// -----------------------------------------------------------------------------
// sc_uni_decode
//
// Stochastic-to-binary decoder for unipolar bitstreams. Counts the 1s seen
// over a window of WINDOW valid stream bits and presents the count as a
// binary result over a valid/ready handshake. The count scales as
// count/WINDOW; no division is done here.
//
// Parameters:
//   DATAWD  width of the running count, window counter and result
//           (WINDOW must not exceed 2**DATAWD - 1)
//   WINDOW  number of valid stream bits per conversion (>= 1)
//
// Ports:
//   clk      in   1       rising-edge clock
//   rst_n    in   1       asynchronous reset, active low
//   iStart   in   1       start, or restart, a conversion
//   iBit     in   1       unipolar stream bit
//   iBitVld  in   1       iBit is valid this cycle
//   iReady   in   1       downstream accepts the result
//   oC       out  DATAWD  count of 1s in the last completed window
//   oValid   out  1       oC holds a new, unconsumed result
//   oBusy    out  1       accumulation in progress
// -----------------------------------------------------------------------------
module sc_uni_decode #(
  parameter int DATAWD = 8,
  parameter int WINDOW = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iStart,
  input  logic              iBit,
  input  logic              iBitVld,
  input  logic              iReady,
  output logic [DATAWD-1:0] oC,
  output logic              oValid,
  output logic              oBusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [DATAWD-1:0] WIN_LAST = DATAWD'(WINDOW);

  state_t            state_q, state_d;
  logic [DATAWD-1:0] acc_q, acc_d;
  logic [DATAWD-1:0] win_q, win_d;
  logic [DATAWD-1:0] c_q, c_d;
  logic              valid_q, valid_d;

  // Count and window values including the bit presented this cycle.
  logic [DATAWD-1:0] acc_inc;
  logic [DATAWD-1:0] win_inc;

  assign acc_inc = acc_q + {{(DATAWD-1){1'b0}}, iBit};
  assign win_inc = win_q + {{(DATAWD-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    win_d   = win_q;
    c_d     = c_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          acc_d   = '0;
          win_d   = '0;
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (iStart) begin
          // Restart: the bit presented alongside the start is discarded,
          // and the previous result is left untouched.
          acc_d = '0;
          win_d = '0;
        end else if (iBitVld) begin
          win_d = win_inc;
          acc_d = acc_inc;
          if (win_inc == WIN_LAST) begin
            c_d     = acc_inc;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // A start is honoured only together with the transfer, so an
        // unconsumed result can never be overwritten.
        if (iReady) begin
          valid_d = 1'b0;
          if (iStart) begin
            acc_d   = '0;
            win_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      win_q   <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

  // All outputs come from registers; iReady reaches none of them directly.
  assign oC     = c_q;
  assign oValid = valid_q;
  assign oBusy  = (state_q == ACCUM);

endmodule

// File: tb/tb_sc_uni_decode.sv
module tb_sc_uni_decode;

  localparam int DATAWD = 8;
  localparam int WINDOW = 255;

  logic              clk;
  logic              rst_n;
  logic              iStart;
  logic              iBit;
  logic              iBitVld;
  logic              iReady;
  logic [DATAWD-1:0] oC;
  logic              oValid;
  logic              oBusy;

  int errors;
  int checks;

  sc_uni_decode #(.DATAWD(DATAWD), .WINDOW(WINDOW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iStart (iStart),
    .iBit   (iBit),
    .iBitVld(iBitVld),
    .iReady (iReady),
    .oC     (oC),
    .oValid (oValid),
    .oBusy  (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance through one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One conversion: start edge, then feed bits until oValid rises (bounded).
  // mode 0 = all zeros, 1 = all ones, 2 = alternating starting with 1.
  // 'gaps' invalid cycles (carrying iBit=1) are inserted at cycles 10,30,...
  task automatic run_conv(input string tag, input int mode, input int gaps, input int exp_c);
    int fed;
    int cyc;
    int busy_n;
    iStart  = 1'b1;
    iBit    = 1'b1;   // presented with the start; must never be counted
    iBitVld = 1'b1;
    step();
    iStart = 1'b0;
    check({tag, "_start_busy"}, 32'(oBusy), 32'd1);
    check({tag, "_start_valid"}, 32'(oValid), 32'd0);
    busy_n = int'(oBusy);
    fed = 0;
    cyc = 0;
    while (!oValid && cyc < 400) begin
      if ((cyc % 20 == 10) && (cyc / 20 < gaps)) begin
        iBitVld = 1'b0;
        iBit    = 1'b1;
      end else begin
        iBitVld = 1'b1;
        case (mode)
          0:       iBit = 1'b0;
          1:       iBit = 1'b1;
          default: iBit = (fed % 2 == 0);
        endcase
        fed++;
      end
      step();
      cyc++;
      busy_n += int'(oBusy);
    end
    iBitVld = 1'b0;
    iBit    = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(WINDOW + gaps));
    check({tag, "_oC"}, 32'(oC), 32'(exp_c));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WINDOW + gaps));
    check({tag, "_busy_done"}, 32'(oBusy), 32'd0);
    $display("conv %s: cycles=%0d oC=%0d busy_cycles=%0d", tag, cyc, oC, busy_n);
  endtask

  // Transfer with iReady high and no start: back to IDLE.
  task automatic transfer(input string tag);
    iReady = 1'b1;
    iStart = 1'b0;
    step();
    check({tag, "_xfer_valid"}, 32'(oValid), 32'd0);
    check({tag, "_xfer_busy"}, 32'(oBusy), 32'd0);
    $display("xfer %s: oValid=%0d oBusy=%0d oC=%0d", tag, oValid, oBusy, oC);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    iStart  = 1'b0;
    iBit    = 1'b0;
    iBitVld = 1'b0;
    iReady  = 1'b1;

    #3;
    check("reset_oC", 32'(oC), 32'd0);
    check("reset_valid", 32'(oValid), 32'd0);
    check("reset_busy", 32'(oBusy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(oBusy), 32'd0);

    // Basic patterns.
    run_conv("ones", 1, 0, 255);
    transfer("ones");
    run_conv("zeros", 0, 0, 0);
    transfer("zeros");
    run_conv("alt", 2, 0, 128);
    transfer("alt");

    // Invalid cycles neither counted nor advancing the window.
    run_conv("gaps", 1, 10, 255);
    transfer("gaps");

    // Back-pressure: hold the result for 5 cycles while bits and a start arrive.
    iReady = 1'b0;
    run_conv("hold", 1, 0, 255);
    for (int i = 0; i < 5; i++) begin
      iBit    = 1'b1;
      iBitVld = 1'b1;
      iStart  = (i == 2);
      step();
      check("hold_valid", 32'(oValid), 32'd1);
      check("hold_oC", 32'(oC), 32'd255);
      check("hold_busy", 32'(oBusy), 32'd0);
      $display("hold cycle %0d: oValid=%0d oC=%0d oBusy=%0d", i, oValid, oC, oBusy);
    end
    iStart  = 1'b0;
    iBitVld = 1'b0;
    transfer("hold");
    check("hold_after_oC", 32'(oC), 32'd255);

    // Restart 100 bits in; a zero result beforehand makes an early write visible.
    run_conv("pre_zero", 0, 0, 0);
    transfer("pre_zero");
    iStart  = 1'b1;
    step();
    iStart  = 1'b0;
    iBit    = 1'b1;
    iBitVld = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check("restart_pre_valid", 32'(oValid), 32'd0);
    check("restart_pre_oC", 32'(oC), 32'd0);
    run_conv("restart", 1, 0, 255);

    // Start together with the DONE transfer: new conversion from that edge.
    iReady = 1'b1;
    run_conv("b2b", 2, 0, 128);
    transfer("b2b");

    // Asynchronous reset 50 bits into a window.
    iStart = 1'b1;
    step();
    iStart  = 1'b0;
    iBit    = 1'b1;
    iBitVld = 1'b1;
    for (int i = 0; i < 50; i++) step();
    check("rst_pre_busy", 32'(oBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_oC", 32'(oC), 32'd0);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    $display("async reset: oC=%0d oValid=%0d oBusy=%0d", oC, oValid, oBusy);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rst_idle_busy", 32'(oBusy), 32'd0);
    check("rst_idle_valid", 32'(oValid), 32'd0);
    run_conv("after_rst", 1, 0, 255);
    transfer("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
